hall_position_counter: RTL
==========================

HALL_POSITION_COUNTER -- requirements
Module: hall_position_counter

Interface
REQ-001 Parameter counter_width, default 32: width of encoder_position and load_value.
REQ-002 Parameter filter_cycles, default 16: consecutive stable cycles needed to accept a new hall code (range 1..255).
REQ-003 Parameter period_width, default 24: width of step_period.
REQ-004 Port sys_clk  in  1: single clock; all logic on rising edge.
REQ-005 Port reset_n  in  1: reset is synchronous and active-low.
REQ-006 Port hall_in  in  3: raw asynchronous hall sensors {C,B,A}.
REQ-007 Port load_en  in  1: one-cycle strobe to preset position.
REQ-008 Port load_value  in  counter_width: preset value.
REQ-009 Port encoder_position  out  counter_width: signed-step position count, modulo 2^counter_width; feeds position control.
REQ-010 Port sector  out  3: current commutation sector 0..5.
REQ-011 Port sector_valid  out  1: a valid hall code has been accepted since reset.
REQ-012 Port dir_out  out  rotation_direction_t: direction of last step (DIR_CW, DIR_CCW, or DIR_NONE).
REQ-013 Port step_pulse  out  1: one-cycle pulse per counted step.
REQ-014 Port step_period  out  period_width: sys_clk cycles between the last two counted steps.
REQ-015 Port hall_error  out  1: one-cycle pulse on invalid code or sector skip.
REQ-016 Port error_count  out  8: saturating error counter.

Function
REQ-017 hall_in SHALL pass through a 2-flop synchronizer before any use.
REQ-018 Filter: a synchronized code differing from the accepted code SHALL be accepted only after it stays unchanged for filter_cycles consecutive cycles; any change restarts the count.
REQ-019 Latency: outputs SHALL update exactly filter_cycles+3 cycles after hall_in changes and then stays stable.
REQ-020 Decode: 001->0, 011->1, 010->2, 110->3, 100->4, 101->5; 000 and 111 are invalid.
REQ-021 First valid accepted code after reset: set sector, set sector_valid=1; no step, no position change, no step_pulse.
REQ-022 New sector == (sector+1) mod 6: encoder_position +1 (wraps all-ones->0), dir_out=DIR_CW, step_pulse=1.
REQ-023 New sector == (sector+5) mod 6: encoder_position -1 (wraps 0->all-ones), dir_out=DIR_CCW, step_pulse=1.
REQ-024 Accepted invalid code: hall_error=1, error_count+1, sector/position/dir unchanged.
REQ-025 Accepted valid code skipping 2 or 3 sectors: hall_error=1, error_count+1, sector updated to new value, position and dir unchanged, no step_pulse.
REQ-026 error_count SHALL saturate at 255.
REQ-027 Period: free counter increments every cycle, saturating at all-ones; on step_pulse step_period<=counter value, counter<=1.
REQ-028 Stall: when the period counter saturates, dir_out SHALL become DIR_NONE; step_period unchanged.
REQ-029 load_en: encoder_position<=load_value next cycle; a step on the same cycle SHALL be discarded for position (load wins), but step_pulse, dir_out, sector, step_period update normally.
REQ-030 Outputs SHALL be registered; no combinational path from hall_in.

Reset
REQ-031 When reset_n=0 at a clock edge: encoder_position=0, sector=0, sector_valid=0, dir_out=DIR_NONE, step_pulse=0, step_period=all-ones, hall_error=0, error_count=0, filter and synchronizer cleared to 000.
REQ-032 Reset mid-filter or mid-step SHALL discard pending codes; after release, REQ-021 applies again.

Verification (filter_cycles=4, counter_width=32)
REQ-033 Reset, hall_in=001 held -> after 7 cycles sector=0, sector_valid=1, position=0, no step_pulse.
REQ-034 Sequence 001,011,010 each held 20 cycles -> position 2, dir CW, two step_pulses, step_period=20.
REQ-035 From position 0 sector 0, hall_in=101 -> position 0xFFFFFFFF, dir CCW.
REQ-036 Glitch 001->011 for 3 cycles then back -> no change; 000 held 10 cycles -> hall_error pulse, error_count=1; 256 such errors -> error_count=255.
REQ-037 Sector 0 -> 010 (skip) -> hall_error, sector=2, position unchanged; load_en with 0x100 coincident with a CW step -> position 0x100, step_pulse=1.
REQ-038 No steps for 2^24 cycles -> dir_out=DIR_NONE; reset_n low mid-filter -> all outputs at REQ-031 values next cycle.

Source files
------------

// File: rtl/hall_position_counter_pkg.sv
// Shared types for the hall-sensor position counter.
// Rotation direction as reported on dir_out.
package hall_position_counter_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_CW   = 2'b01,
    DIR_CCW  = 2'b10
  } rotation_direction_t;

endpackage

// File: rtl/hall_position_counter.sv
// Hall-sensor commutation decoder: synchronizes and debounces the three hall
// lines, tracks sector, counts signed steps, measures step period, flags errors.
module hall_position_counter
  import hall_position_counter_pkg::*;
#(
  parameter int counter_width = 32,
  parameter int filter_cycles = 16,
  parameter int period_width  = 24
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic [2:0]               hall_in,
  input  logic                     load_en,
  input  logic [counter_width-1:0] load_value,
  output logic [counter_width-1:0] encoder_position,
  output logic [2:0]               sector,
  output logic                     sector_valid,
  output rotation_direction_t      dir_out,
  output logic                     step_pulse,
  output logic [period_width-1:0]  step_period,
  output logic                     hall_error,
  output logic [7:0]               error_count
);

  localparam int                    FW         = $clog2(filter_cycles + 1);
  localparam logic [FW-1:0]         FILT_MAX   = FW'(filter_cycles);
  localparam logic [period_width-1:0] PERIOD_MAX = '1;

  // {valid, sector}; 000 and 111 decode as invalid.
  function automatic logic [3:0] decode_hall(input logic [2:0] code);
    case (code)
      3'b001:  return {1'b1, 3'd0};
      3'b011:  return {1'b1, 3'd1};
      3'b010:  return {1'b1, 3'd2};
      3'b110:  return {1'b1, 3'd3};
      3'b100:  return {1'b1, 3'd4};
      3'b101:  return {1'b1, 3'd5};
      default: return 4'b0000;
    endcase
  endfunction

  // Forward distance from from_s to to_s around the six-sector ring.
  function automatic logic [2:0] sector_delta(input logic [2:0] to_s,
                                              input logic [2:0] from_s);
    logic [3:0] d;
    d = {1'b0, to_s} + 4'd6 - {1'b0, from_s};
    if (d >= 4'd6) d = d - 4'd6;
    return d[2:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [period_width-1:0] sat_inc_period(
      input logic [period_width-1:0] v);
    return (v == PERIOD_MAX) ? v : v + period_width'(1);
  endfunction

  logic [2:0]              hall_sync_p0;
  logic [2:0]              hall_sync_p1;
  logic [2:0]              cand_code;
  logic [FW-1:0]           stable_cnt;
  logic [2:0]              acc_code;
  logic [period_width-1:0] period_cnt;

  logic       accept;
  logic [3:0] new_info;
  logic       new_valid;
  logic [2:0] new_sector;
  logic [2:0] delta;
  logic       is_cw;
  logic       is_ccw;
  logic       is_skip;
  logic       is_inv;
  logic       is_step;

  always_comb begin
    accept     = (stable_cnt == FILT_MAX) && (cand_code != acc_code);
    new_info   = decode_hall(cand_code);
    new_valid  = new_info[3];
    new_sector = new_info[2:0];
    delta      = sector_delta(new_sector, sector);
    is_cw      = accept && new_valid && sector_valid && (delta == 3'd1);
    is_ccw     = accept && new_valid && sector_valid && (delta == 3'd5);
    is_skip    = accept && new_valid && sector_valid &&
                 (delta >= 3'd2) && (delta <= 3'd4);
    is_inv     = accept && !new_valid;
    is_step    = is_cw || is_ccw;
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      hall_sync_p0     <= 3'b000;
      hall_sync_p1     <= 3'b000;
      cand_code        <= 3'b000;
      stable_cnt       <= '0;
      acc_code         <= 3'b000;
      // Period is measured from reset as if a step had occurred there.
      period_cnt       <= period_width'(1);
      encoder_position <= '0;
      sector           <= 3'd0;
      sector_valid     <= 1'b0;
      dir_out          <= DIR_NONE;
      step_pulse       <= 1'b0;
      step_period      <= PERIOD_MAX;
      hall_error       <= 1'b0;
      error_count      <= 8'd0;
    end else begin
      // Stage p0/p1: two-flop synchronizer on the raw hall lines.
      hall_sync_p0 <= hall_in;
      hall_sync_p1 <= hall_sync_p0;

      // Debounce: count how long the synchronized code has held still.
      if (hall_sync_p1 != cand_code) begin
        cand_code  <= hall_sync_p1;
        stable_cnt <= FW'(1);
      end else if (stable_cnt != FILT_MAX) begin
        stable_cnt <= stable_cnt + FW'(1);
      end

      if (accept) acc_code <= cand_code;

      // Output stage: registered sector, step, error and period updates.
      step_pulse <= is_step;
      hall_error <= is_inv || is_skip;
      if (is_inv || is_skip) error_count <= sat_inc8(error_count);

      if (accept && new_valid) begin
        sector       <= new_sector;
        sector_valid <= 1'b1;
      end

      // A preset overrides any step landing on the same cycle.
      if (load_en)     encoder_position <= load_value;
      else if (is_cw)  encoder_position <= encoder_position + counter_width'(1);
      else if (is_ccw) encoder_position <= encoder_position - counter_width'(1);

      if (is_step) begin
        step_period <= period_cnt;
        period_cnt  <= period_width'(1);
        dir_out     <= is_cw ? DIR_CW : DIR_CCW;
      end else if (period_cnt == PERIOD_MAX) begin
        dir_out <= DIR_NONE;
      end else begin
        period_cnt <= sat_inc_period(period_cnt);
      end
    end
  end

endmodule
